// File: rtl/multiplier_32bit.sv
// -----------------------------------------------------------------------------
// multiplier_32bit
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits, one
// partial-product step per clock. There is no start strobe: a new product
// begins whenever in0/in1 differ from the last captured pair, and on the first
// edge after reset. done rises WIDTH edges after the capture edge. An operand
// change at any point abandons the running product and starts over.
//
// Optional build macro:
//   MULT_SIGNED_EN  operands are two's complement and result is the signed
//                   product. Latency and handshake are unchanged.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low
//   in0     multiplicand (WIDTH)
//   in1     multiplier   (WIDTH)
//   done    high while result holds the product of the applied in0/in1
//   result  last completed product (2*WIDTH)
// -----------------------------------------------------------------------------
module multiplier_32bit #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in0,
   input  logic [WIDTH-1:0]   in1,
   output logic               done,
   output logic [2*WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state;
   logic               vld;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   cap_a;
   logic [WIDTH-1:0]   cap_b;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   logic               start;
   logic               last;
   logic [2*WIDTH-1:0] acc_next;

   // Widen the multiplicand to the accumulator width.
   function automatic logic [2*WIDTH-1:0] ext_mcand(input logic [WIDTH-1:0] a);
`ifdef MULT_SIGNED_EN
      return {{WIDTH{a[WIDTH-1]}}, a};
`else
      return {{WIDTH{1'b0}}, a};
`endif
   endfunction

`ifdef MULT_SIGNED_EN
   // The multiplier's MSB carries weight -2^(WIDTH-1), so the last step
   // subtracts the shifted multiplicand instead of adding it.
   function automatic logic [2*WIDTH-1:0] acc_step(input logic [2*WIDTH-1:0] a,
                                                   input logic [2*WIDTH-1:0] m,
                                                   input logic               b,
                                                   input logic               fin);
      if (b && fin) return a - m;
      if (b)        return a + m;
      return a;
   endfunction
`else
   function automatic logic [2*WIDTH-1:0] acc_step(input logic [2*WIDTH-1:0] a,
                                                   input logic [2*WIDTH-1:0] m,
                                                   input logic               b);
      if (b) return a + m;
      return a;
   endfunction
`endif

   assign start = !vld || (in0 != cap_a) || (in1 != cap_b);
   assign last  = (state == BUSY) && (cnt == CW'(WIDTH - 1));

`ifdef MULT_SIGNED_EN
   assign acc_next = acc_step(acc, mcand, mplier[0], last);
`else
   assign acc_next = acc_step(acc, mcand, mplier[0]);
`endif

   // Control: state, handshake, counter and the visible result.
   // A start always wins over completion, so a change on the final edge
   // never exposes the abandoned product.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         vld    <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         result <= '0;
      end else if (start) begin
         state <= BUSY;
         vld   <= 1'b1;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         case (state)
            BUSY: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  result <= acc_next;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath: captured operands and shift-add registers. Their contents are
   // only meaningful once vld is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (start) begin
         cap_a  <= in0;
         cap_b  <= in1;
         acc    <= '0;
         mcand  <= ext_mcand(in0);
         mplier <= in1;
      end else if (state == BUSY) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: tb/tb_multiplier_32bit.sv
module tb_multiplier_32bit;

   logic        clk;
   logic        rst;
   logic [31:0] in0;
   logic [31:0] in1;
   logic        done;
   logic [63:0] result;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      string       nm;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] prev;

   multiplier_32bit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .in0    (in0),
      .in1    (in1),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      in0 = a;
      in1 = b;
   endtask

   // n edges during which done must stay low and result must not move.
   task automatic busy_hold(input int n, input logic [63:0] p, input string nm);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (done !== 1'b0 || result !== p) ok = 1'b0;
      end
      chk({nm, " busy hold"}, {63'd0, ok}, 64'd1);
   endtask

   // Capture edge, 31 busy edges, completion on the 32nd, then hold to 40.
   task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input logic [63:0] p,
                          input string nm);
      apply(a, b);
      @(posedge clk);
      #1;
      chk({nm, " capture done"}, {63'd0, done}, 64'd0);
      chk({nm, " capture result"}, result, p);
      busy_hold(31, p, nm);
      @(posedge clk);
      #1;
      chk({nm, " done at 32"}, {63'd0, done}, 64'd1);
      chk({nm, " result"}, result, exp);
      repeat (8) @(posedge clk);
      #1;
      chk({nm, " result at 40"}, result, exp);
      chk({nm, " done at 40"}, {63'd0, done}, 64'd1);
   endtask

   initial begin
      vecs.push_back('{32'd6, 32'd6, 64'd36, "6x6"});
      vecs.push_back('{32'd5, 32'd3, 64'd15, "5x3"});
      vecs.push_back('{32'd7, 32'd2, 64'd14, "7x2"});
      vecs.push_back('{32'd4, 32'd4, 64'd16, "4x4"});
      vecs.push_back('{32'd0, 32'd5, 64'd0,  "0x5"});
      vecs.push_back('{32'd15, 32'd1, 64'd15, "15x1"});
`ifdef MULT_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, "m1xm1"});
      vecs.push_back('{32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000, "minx2"});
      vecs.push_back('{32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, "m3x5"});
      vecs.push_back('{32'd5, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1, "5xm3"});
`else
      vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "maxxmax"});
      vecs.push_back('{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, "msbx2"});
`endif

      // Reset held with arbitrary operands.
      rst = 1'b0;
      in0 = 32'd123;
      in1 = 32'd456;
      repeat (3) @(posedge clk);
      #1;
      chk("reset result", result, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);

      // First edge after release starts 0x0.
      @(negedge clk);
      in0 = 32'd0;
      in1 = 32'd0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("post-reset capture done", {63'd0, done}, 64'd0);
      busy_hold(31, 64'd0, "post-reset");
      @(posedge clk);
      #1;
      chk("post-reset done at 32", {63'd0, done}, 64'd1);
      chk("post-reset result", result, 64'd0);

      prev = 64'd0;
      foreach (vecs[i]) begin
         run_vec(vecs[i].a, vecs[i].b, vecs[i].exp, prev, vecs[i].nm);
         prev = vecs[i].exp;
      end

      // Restart: 6x6 abandoned two edges in, 5x3 must complete cleanly.
      apply(32'd6, 32'd6);
      @(posedge clk);
      #1;
      chk("restart first capture done", {63'd0, done}, 64'd0);
      busy_hold(1, prev, "restart early");
      apply(32'd5, 32'd3);
      @(posedge clk);
      #1;
      chk("restart second capture result", result, prev);
      busy_hold(31, prev, "restart");
      @(posedge clk);
      #1;
      chk("restart done", {63'd0, done}, 64'd1);
      chk("restart result", result, 64'd15);

      // Operand change coinciding with the final iteration: restart wins.
      apply(32'd7, 32'd2);
      @(posedge clk);
      #1;
      busy_hold(31, 64'd15, "final-edge first");
      apply(32'd4, 32'd4);
      @(posedge clk);
      #1;
      chk("final-edge done stays low", {63'd0, done}, 64'd0);
      chk("final-edge result unchanged", result, 64'd15);
      busy_hold(31, 64'd15, "final-edge second");
      @(posedge clk);
      #1;
      chk("final-edge done", {63'd0, done}, 64'd1);
      chk("final-edge result", result, 64'd16);

      // Asynchronous reset between edges while busy.
      apply(32'd15, 32'd1);
      @(posedge clk);
      #1;
      busy_hold(4, 64'd16, "midreset pre");
      #2;
      rst = 1'b0;
      #1;
      chk("midreset result", result, 64'd0);
      chk("midreset done", {63'd0, done}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset capture done", {63'd0, done}, 64'd0);
      busy_hold(31, 64'd0, "midreset");
      @(posedge clk);
      #1;
      chk("midreset fresh done", {63'd0, done}, 64'd1);
      chk("midreset fresh result", result, 64'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
